sprite_blit: RTL and testbench



---
 rtl/sprite_blit_if.sv | 26 ++
 rtl/sprite_blit.sv | 111 +++++++++++
 tb/tb_sprite_blit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blit_if.sv
// Sprite blitter bus: renderer request, sprite ROM port
// and framebuffer write stream.
interface sprite_blit_if;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic       busy;
  logic       done;
  logic [8:0] rom_addr;
  logic [7:0] rom_q;
  logic       fb_we;
  logic [14:0] fb_addr;
  logic [7:0] fb_data;

  modport master (
    output start, x0, y0, rom_q,
    input  busy, done, rom_addr,
    input  fb_we, fb_addr, fb_data
  );

  modport slave (
    input  start, x0, y0, rom_q,
    output busy, done, rom_addr,
    output fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/sprite_blit.sv
// Raster-order sprite ROM reader that streams opaque,
// clipped pixels into the framebuffer write port.
module sprite_blit #(
  parameter int         SPR_W     = 20,
  parameter int         SPR_H     = 20,
  parameter int         FB_W      = 160,
  parameter int         FB_H      = 120,
  parameter logic [7:0] TRANSP    = 8'hFF,
  parameter int         TRANSP_EN = 1
) (
  input logic          clock,
  input logic          reset,
  sprite_blit_if.slave bus
);

  localparam int SXW = $clog2(SPR_W);
  localparam int SYW = $clog2(SPR_H);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     r_state;
  logic [SXW-1:0] r_sx;
  logic [SYW-1:0] r_sy;
  logic [7:0]     r_x0;
  logic [6:0]     r_y0;
  logic [8:0]     r_rom_addr;
  logic           r_valid_d;
  logic           r_clip_d;
  logic [14:0]    r_fb_addr;

  logic [8:0]  w_px;
  logic [7:0]  w_py;
  logic [16:0] w_lin;
  logic        w_last;
  logic        w_eol;
  logic        w_key;

  // px/py belong to the address currently on rom_addr
  assign w_px  = 9'(r_x0) + 9'(r_sx);
  assign w_py  = 8'(r_y0) + 8'(r_sy);
  assign w_lin = 17'(w_py) * 17'(FB_W) + 17'(w_px);

  assign w_eol  = (r_sx == SXW'(SPR_W - 1));
  assign w_last = w_eol && (r_sy == SYW'(SPR_H - 1));

  assign w_key = (TRANSP_EN != 0) && (bus.rom_q == TRANSP);

  assign bus.rom_addr = r_rom_addr;
  assign bus.fb_addr  = r_fb_addr;
  assign bus.fb_data  = bus.rom_q;
  assign bus.fb_we    = r_valid_d & ~r_clip_d & ~w_key;
  assign bus.busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign bus.done     = (r_state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sx       <= '0;
      r_sy       <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_rom_addr <= '0;
      r_valid_d  <= 1'b0;
      r_clip_d   <= 1'b0;
      r_fb_addr  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_valid_d <= 1'b0;
          if (bus.start) begin
            r_x0       <= bus.x0;
            r_y0       <= bus.y0;
            r_sx       <= '0;
            r_sy       <= '0;
            r_rom_addr <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_valid_d <= 1'b1;
          r_clip_d  <= (w_px >= 9'(FB_W)) ||
                       (w_py >= 8'(FB_H));
          r_fb_addr <= w_lin[14:0];
          if (w_last) begin
            r_state <= S_FLUSH;
          end else begin
            r_rom_addr <= r_rom_addr + 9'd1;
            if (w_eol) begin
              r_sx <= '0;
              r_sy <= r_sy + SYW'(1);
            end else begin
              r_sx <= r_sx + SXW'(1);
            end
          end
        end
        S_FLUSH: begin
          r_valid_d <= 1'b0;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_valid_d <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: timing, keying,
// clipping, ignored starts and mid-blit reset.
module tb_sprite_blit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sprite_blit_if a ();
  sprite_blit_if b ();

  sprite_blit #(.TRANSP_EN(1)) u_dut (
    .clock(clock), .reset(reset), .bus(a.slave)
  );
  sprite_blit #(.TRANSP_EN(0)) u_raw (
    .clock(clock), .reset(reset), .bus(b.slave)
  );

  logic [7:0] rom [0:399];

  always @(posedge clock) begin
    a.rom_q <= rom[a.rom_addr];
    b.rom_q <= rom[b.rom_addr];
  end

  logic        sel = 1'b0;
  logic        m_we, m_busy, m_done;
  logic [14:0] m_addr;
  logic [7:0]  m_data;
  logic [8:0]  m_raddr;

  assign m_we    = sel ? b.fb_we    : a.fb_we;
  assign m_busy  = sel ? b.busy     : a.busy;
  assign m_done  = sel ? b.done     : a.done;
  assign m_addr  = sel ? b.fb_addr  : a.fb_addr;
  assign m_data  = sel ? b.fb_data  : a.fb_data;
  assign m_raddr = sel ? b.rom_addr : a.rom_addr;

  int errors = 0;
  int checks = 0;

  int n_edges, n_wr, n_first, n_last, n_max;
  int n_firstk, n_bad, n_seq;
  logic n_busydone;

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 400; i++) rom[i] = v;
  endtask

  task automatic drive_start(input logic s,
                             input logic [7:0] x,
                             input logic [6:0] y);
    if (sel) begin
      b.start = s; b.x0 = x; b.y0 = y;
    end else begin
      a.start = s; a.x0 = x; a.y0 = y;
    end
  endtask

  // Edges are counted with the start edge as 1
  task automatic blit(input logic [7:0] x,
                      input logic [6:0] y,
                      input int exp_data,
                      input bit poke);
    int k;
    bit fin;
    n_wr = 0; n_first = -1; n_last = -1; n_max = -1;
    n_firstk = -1; n_bad = 0; n_seq = 0;
    n_busydone = 1'bx; n_edges = -1; fin = 1'b0;
    @(negedge clock);
    drive_start(1'b1, x, y);
    @(posedge clock);
    k = 1;
    #1 drive_start(1'b0, x, y);
    while (!fin) begin
      @(negedge clock);
      if (m_we) begin
        n_wr++;
        if (n_first < 0) begin
          n_first = int'(m_addr); n_firstk = k;
        end
        n_last = int'(m_addr);
        if (int'(m_addr) > n_max) n_max = int'(m_addr);
        if (exp_data >= 0 && int'(m_data) != exp_data)
          n_bad++;
      end
      if (k <= 400 && m_raddr !== 9'(k - 1)) n_seq++;
      if (m_done) begin
        n_busydone = m_busy; n_edges = k; fin = 1'b1;
      end else if (k >= 1000) begin
        fin = 1'b1;
      end else begin
        if (poke && k == 50) drive_start(1'b1, 8'd0, 7'd0);
        @(posedge clock);
        k++;
        #1 drive_start(1'b0, x, y);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (a.busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy got %b want 0", a.busy); end
    checks++;
    if (a.done !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b want 0", a.done); end
    checks++;
    if (a.fb_we !== 1'b0) begin errors++;
      $display("FAIL rst_we got %b want 0", a.fb_we); end
    checks++;
    if (a.rom_addr !== 9'd0) begin errors++;
      $display("FAIL rst_raddr got %0d want 0", a.rom_addr); end
    checks++;
    if (a.fb_addr !== 15'd0) begin errors++;
      $display("FAIL rst_faddr got %0d want 0", a.fb_addr); end
    reset = 1'b0;
  endtask

  task automatic test_opaque;
    fill(8'd232);
    blit(8'd10, 7'd5, 232, 1'b0);
    checks++;
    if (n_wr != 400) begin errors++;
      $display("FAIL op_count got %0d want 400", n_wr); end
    checks++;
    if (n_first != 810) begin errors++;
      $display("FAIL op_first got %0d want 810", n_first); end
    checks++;
    if (n_last != 3869) begin errors++;
      $display("FAIL op_last got %0d want 3869", n_last); end
    checks++;
    if (n_firstk != 2) begin errors++;
      $display("FAIL op_lat got %0d want 2", n_firstk); end
    checks++;
    if (n_bad != 0) begin errors++;
      $display("FAIL op_data got %0d bad want 0", n_bad); end
    checks++;
    if (n_edges != 402) begin errors++;
      $display("FAIL op_edges got %0d want 402", n_edges); end
    checks++;
    if (n_busydone !== 1'b0) begin errors++;
      $display("FAIL op_busy_done got %b want 0", n_busydone); end
  endtask

  task automatic test_addr_seq;
    fill(8'd7);
    blit(8'd0, 7'd0, 7, 1'b0);
    checks++;
    if (n_seq != 0) begin errors++;
      $display("FAIL seq_addr got %0d bad want 0", n_seq); end
  endtask

  task automatic test_transp;
    fill(8'hFF);
    rom[0] = 8'd232; rom[399] = 8'd232;
    blit(8'd0, 7'd0, 232, 1'b0);
    checks++;
    if (n_wr != 2) begin errors++;
      $display("FAIL key_count got %0d want 2", n_wr); end
    checks++;
    if (n_first != 0) begin errors++;
      $display("FAIL key_first got %0d want 0", n_first); end
    checks++;
    if (n_last != 3059) begin errors++;
      $display("FAIL key_last got %0d want 3059", n_last); end
    sel = 1'b1;
    blit(8'd0, 7'd0, -1, 1'b0);
    checks++;
    if (n_wr != 400) begin errors++;
      $display("FAIL nokey_count got %0d want 400", n_wr); end
    checks++;
    if (n_edges != 402) begin errors++;
      $display("FAIL nokey_edges got %0d want 402", n_edges); end
    sel = 1'b0;
  endtask

  task automatic test_clip;
    fill(8'h1C);
    blit(8'd150, 7'd110, 28, 1'b0);
    checks++;
    if (n_wr != 100) begin errors++;
      $display("FAIL clip_count got %0d want 100", n_wr); end
    checks++;
    if (n_first != 17750) begin errors++;
      $display("FAIL clip_first got %0d want 17750", n_first); end
    checks++;
    if (n_max != 19199) begin errors++;
      $display("FAIL clip_max got %0d want 19199", n_max); end
    blit(8'd200, 7'd0, 28, 1'b0);
    checks++;
    if (n_wr != 0) begin errors++;
      $display("FAIL clipx_count got %0d want 0", n_wr); end
    checks++;
    if (n_edges != 402) begin errors++;
      $display("FAIL clipx_edges got %0d want 402", n_edges); end
  endtask

  task automatic test_back_to_back;
    int k;
    int ndone;
    fill(8'd232);
    blit(8'd10, 7'd5, 232, 1'b1);
    checks++;
    if (n_wr != 400) begin errors++;
      $display("FAIL b2b_count got %0d want 400", n_wr); end
    checks++;
    if (n_first != 810) begin errors++;
      $display("FAIL b2b_first got %0d want 810", n_first); end
    checks++;
    if (n_edges != 402) begin errors++;
      $display("FAIL b2b_edges got %0d want 402", n_edges); end
    // start held over the DONE edge and the first IDLE edge
    a.start = 1'b1; a.x0 = 8'd0; a.y0 = 7'd0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (a.busy !== 1'b0 || a.done !== 1'b0) begin errors++;
      $display("FAIL b2b_done_start got busy=%b done=%b want 0 0",
               a.busy, a.done); end
    @(posedge clock);
    #1 a.start = 1'b0;
    @(negedge clock);
    checks++;
    if (a.busy !== 1'b1 || a.rom_addr !== 9'd0) begin errors++;
      $display("FAIL b2b_idle_start got busy=%b raddr=%0d want 1 0",
               a.busy, a.rom_addr); end
    k = 1; ndone = 0;
    while (ndone == 0 && k < 1000) begin
      @(posedge clock); k++;
      @(negedge clock);
      if (a.done) ndone = 1;
    end
    checks++;
    if (k != 402) begin errors++;
      $display("FAIL b2b_second_edges got %0d want 402", k); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    fill(8'd232);
    @(negedge clock);
    a.start = 1'b1; a.x0 = 8'd10; a.y0 = 7'd5;
    @(posedge clock);
    #1 a.start = 1'b0;
    repeat (136) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (a.fb_we !== 1'b0 || a.busy !== 1'b0) begin errors++;
      $display("FAIL mid_rst got we=%b busy=%b want 0 0",
               a.fb_we, a.busy); end
    checks++;
    if (a.done !== 1'b0 || a.rom_addr !== 9'd0) begin errors++;
      $display("FAIL mid_rst got done=%b raddr=%0d want 0 0",
               a.done, a.rom_addr); end
    reset = 1'b0;
    ndone = 0;
    repeat (450) begin
      @(negedge clock);
      if (a.done || a.fb_we) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++;
      $display("FAIL mid_rst_quiet got %0d want 0", ndone); end
    blit(8'd10, 7'd5, 232, 1'b0);
    checks++;
    if (n_edges != 402 || n_wr != 400) begin errors++;
      $display("FAIL mid_rst_fresh got edges=%0d wr=%0d want 402 400",
               n_edges, n_wr); end
  endtask

  initial begin
    a.start = 1'b0; a.x0 = '0; a.y0 = '0;
    b.start = 1'b0; b.x0 = '0; b.y0 = '0;
    fill(8'd0);
    test_reset;
    test_opaque;
    test_addr_seq;
    test_transp;
    test_clip;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
